axis_frame_length_adjust: RTL and testbench

AXIS_FRAME_LENGTH_ADJUST -- requirements
Module: axis_frame_length_adjust

---
 rtl/axis_frame_length_adjust.sv | 213 +++++++++++++++++++++
 tb/tb_axis_frame_length_adjust.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_length_adjust.sv
// AXI-Stream frame length adjuster: pads short frames with zero beats up to a minimum length.
// Define AXIS_FLA_TRUNCATE_EN to also cut frames at length_max and drop the rest of the frame.
module axis_frame_length_adjust #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic [LEN_WIDTH-1:0]  length_min,
  input  logic [LEN_WIDTH-1:0]  length_max,
  output logic                  status_valid,
  output logic                  status_frame_pad,
  output logic                  status_frame_truncate,
  output logic [LEN_WIDTH-1:0]  status_frame_length,
  output logic [LEN_WIDTH-1:0]  status_frame_original_length
);

`ifdef AXIS_FLA_TRUNCATE_EN
  typedef enum logic [1:0] {TRANSFER, PAD, DROP} state_t;
`else
  typedef enum logic {TRANSFER, PAD} state_t;
`endif

  localparam logic [LEN_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH:0]   ONE_X   = (LEN_WIDTH + 1)'(1);

  state_t                state_q;
  logic [LEN_WIDTH-1:0]  out_cnt_q, in_cnt_q, min_q;
  logic [DATA_WIDTH-1:0] m_tdata_q;
  logic                  m_tvalid_q, m_tlast_q;
  logic [ID_WIDTH-1:0]   m_tid_q;
  logic [DEST_WIDTH-1:0] m_tdest_q;
  logic [USER_WIDTH-1:0] m_tuser_q;
  logic                  status_valid_q, status_pad_q;
  logic [LEN_WIDTH-1:0]  status_len_q, status_orig_q;

  logic                  frame_start, out_slot, s_ready, s_fire;
  logic [LEN_WIDTH-1:0]  min_in, min_cur, out_len, in_sat;
  logic [LEN_WIDTH:0]    out_inc;

`ifdef AXIS_FLA_TRUNCATE_EN
  logic [LEN_WIDTH-1:0]  max_q, max_cur;
  logic                  status_trunc_q;
`else
  logic                  unused_length_max;
  assign unused_length_max = ^length_max;
`endif

  always_comb begin
    frame_start = (state_q == TRANSFER) && (in_cnt_q == '0);
`ifdef AXIS_FLA_TRUNCATE_EN
    // length_max == 0 means "no limit", so it must not pull the minimum down to 0
    min_in  = (length_max != '0 && length_max < length_min) ? length_max : length_min;
    max_cur = frame_start ? length_max : max_q;
`else
    min_in  = length_min;
`endif
    min_cur  = frame_start ? min_in : min_q;
    out_inc  = {1'b0, out_cnt_q} + ONE_X;
    out_len  = out_inc[LEN_WIDTH] ? CNT_MAX : out_inc[LEN_WIDTH-1:0];
    in_sat   = (in_cnt_q == CNT_MAX) ? in_cnt_q : in_cnt_q + ONE;
    out_slot = m_axis_tready || !m_tvalid_q;
    s_ready  = 1'b0;
    case (state_q)
      TRANSFER: s_ready = out_slot;
`ifdef AXIS_FLA_TRUNCATE_EN
      DROP:     s_ready = 1'b1;
`endif
      default:  s_ready = 1'b0;
    endcase
  end

  assign s_axis_tready = s_ready && !rst;
  assign s_fire        = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= TRANSFER;
      out_cnt_q      <= '0;
      in_cnt_q       <= '0;
      min_q          <= '0;
      m_tdata_q      <= '0;
      m_tvalid_q     <= 1'b0;
      m_tlast_q      <= 1'b0;
      m_tid_q        <= '0;
      m_tdest_q      <= '0;
      m_tuser_q      <= '0;
      status_valid_q <= 1'b0;
      status_pad_q   <= 1'b0;
      status_len_q   <= '0;
      status_orig_q  <= '0;
`ifdef AXIS_FLA_TRUNCATE_EN
      max_q          <= '0;
      status_trunc_q <= 1'b0;
`endif
    end else begin
      status_valid_q <= 1'b0;
      if (m_axis_tready) m_tvalid_q <= 1'b0;
      case (state_q)
        TRANSFER: if (s_fire) begin
          if (frame_start) begin
            min_q <= min_in;
`ifdef AXIS_FLA_TRUNCATE_EN
            max_q <= length_max;
`endif
          end
          m_tdata_q  <= s_axis_tdata;
          m_tid_q    <= s_axis_tid;
          m_tdest_q  <= s_axis_tdest;
          m_tuser_q  <= s_axis_tuser;
          m_tvalid_q <= 1'b1;
          m_tlast_q  <= 1'b0;
          out_cnt_q  <= out_len;
          in_cnt_q   <= in_sat;
          if (s_axis_tlast) begin
            if (out_inc < {1'b0, min_cur}) begin
              state_q <= PAD;
            end else begin
              m_tlast_q      <= 1'b1;
              status_valid_q <= 1'b1;
              status_pad_q   <= 1'b0;
              status_len_q   <= out_len;
              status_orig_q  <= in_sat;
              out_cnt_q      <= '0;
              in_cnt_q       <= '0;
`ifdef AXIS_FLA_TRUNCATE_EN
              status_trunc_q <= 1'b0;
`endif
            end
          end
`ifdef AXIS_FLA_TRUNCATE_EN
          else if (max_cur != '0 && out_inc == {1'b0, max_cur}) begin
            m_tlast_q <= 1'b1;
            state_q   <= DROP;
          end
`endif
        end
        // pad beats keep tid/tdest/tuser of the last input beat already in the output register
        PAD: if (out_slot) begin
          m_tdata_q  <= '0;
          m_tvalid_q <= 1'b1;
          m_tlast_q  <= 1'b0;
          out_cnt_q  <= out_len;
          if (out_inc >= {1'b0, min_cur}) begin
            m_tlast_q      <= 1'b1;
            state_q        <= TRANSFER;
            status_valid_q <= 1'b1;
            status_pad_q   <= 1'b1;
            status_len_q   <= out_len;
            status_orig_q  <= in_cnt_q;
            out_cnt_q      <= '0;
            in_cnt_q       <= '0;
`ifdef AXIS_FLA_TRUNCATE_EN
            status_trunc_q <= 1'b0;
`endif
          end
        end
`ifdef AXIS_FLA_TRUNCATE_EN
        DROP: if (s_fire) begin
          in_cnt_q <= in_sat;
          if (s_axis_tlast) begin
            state_q        <= TRANSFER;
            status_valid_q <= 1'b1;
            status_pad_q   <= 1'b0;
            status_trunc_q <= 1'b1;
            status_len_q   <= out_cnt_q;
            status_orig_q  <= in_sat;
            out_cnt_q      <= '0;
            in_cnt_q       <= '0;
          end
        end
`endif
        default: state_q <= TRANSFER;
      endcase
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tid    = m_tid_q;
  assign m_axis_tdest  = m_tdest_q;
  assign m_axis_tuser  = m_tuser_q;

  assign status_valid                 = status_valid_q;
  assign status_frame_pad             = status_pad_q;
  assign status_frame_length          = status_len_q;
  assign status_frame_original_length = status_orig_q;
`ifdef AXIS_FLA_TRUNCATE_EN
  assign status_frame_truncate        = status_trunc_q;
`else
  assign status_frame_truncate        = 1'b0;
`endif

endmodule

// File: tb/tb_axis_frame_length_adjust.sv
// Scoreboard bench for axis_frame_length_adjust; expectations follow AXIS_FLA_TRUNCATE_EN if defined.
module tb_axis_frame_length_adjust;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [7:0] id;
    logic [7:0] dest;
    logic       u;
  } beat_t;

  typedef struct packed {
    logic        pad;
    logic        trunc;
    logic [15:0] len;
    logic [15:0] orig;
  } status_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [7:0]  s_axis_tid, s_axis_tdest;
  logic [0:0]  s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [7:0]  m_axis_tid, m_axis_tdest;
  logic [0:0]  m_axis_tuser;
  logic [15:0] length_min, length_max;
  logic        status_valid, status_frame_pad, status_frame_truncate;
  logic [15:0] status_frame_length, status_frame_original_length;

  int    checks = 0;
  int    errors = 0;
  beat_t   exp_q[$];
  status_t st_q[$];
  logic  mon_en  = 1'b1;
  logic  rnd_rdy = 1'b0;
  logic  gaps    = 1'b0;
  logic  stall_q = 1'b0;
  beat_t prev_b;

  axis_frame_length_adjust #(
    .DATA_WIDTH(8), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1), .LEN_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid), .s_axis_tdest(s_axis_tdest),
    .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
    .m_axis_tuser(m_axis_tuser),
    .length_min(length_min), .length_max(length_max),
    .status_valid(status_valid), .status_frame_pad(status_frame_pad),
    .status_frame_truncate(status_frame_truncate), .status_frame_length(status_frame_length),
    .status_frame_original_length(status_frame_original_length)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.d = m_axis_tdata; b.l = m_axis_tlast; b.id = m_axis_tid;
    b.dest = m_axis_tdest; b.u = m_axis_tuser[0];
    return b;
  endfunction

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares each output handshake and status pulse against the scoreboard queues
  always @(negedge clk) begin
    beat_t   b, e;
    status_t s, es;
    if (!rst) begin
      b = cur_beat();
      if (stall_q && mon_en) chk("hold_stable", {m_axis_tvalid, b}, {1'b1, prev_b});
      if (mon_en && m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", {1'b1, b}, '0);
        else begin
          e = exp_q.pop_front();
          chk("beat", b, e);
        end
      end
      if (status_valid) begin
        s = '{status_frame_pad, status_frame_truncate, status_frame_length,
              status_frame_original_length};
        if (st_q.size() == 0) chk("unexpected_status", {1'b1, s}, '0);
        else begin
          es = st_q.pop_front();
          chk("status", s, es);
        end
      end
    end
    stall_q = mon_en && !rst && m_axis_tvalid && !m_axis_tready;
    prev_b  = cur_beat();
  end

  task automatic wait_accept();
    int t = 0;
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      t++;
      if (t > 2000) begin
        errors++; checks++;
        $display("FAIL accept_timeout: got no tready expected tready within 2000 cycles");
        $fatal(1, "input stalled");
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input int mn, input int mx,
                            input logic ep, input logic et, input int elen, input int eorig);
    beat_t b;
    status_t s;
    for (int k = 0; k < elen; k++) begin
      b.d = (k < n) ? base + 8'(k) : 8'h00;
      b.l = (k == elen - 1);
      b.id = base ^ 8'h5A; b.dest = ~base; b.u = base[0];
      exp_q.push_back(b);
    end
    s = '{ep, et, 16'(elen), 16'(eorig)};
    st_q.push_back(s);
    length_min = 16'(mn);
    length_max = 16'(mx);
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = base + 8'(i);
      s_axis_tlast  = (i == n - 1);
      s_axis_tid    = base ^ 8'h5A;
      s_axis_tdest  = ~base;
      s_axis_tuser  = base[0];
      wait_accept();
      s_axis_tvalid = 1'b0;
      if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end
  endtask

  function automatic void model(input int n, input int mn, input int mx,
                                output logic ep, output logic et, output int elen);
    int eff;
    eff = mn;
    et  = 1'b0;
`ifdef AXIS_FLA_TRUNCATE_EN
    if (mx != 0 && mx < mn) eff = mx;
    if (mx != 0 && n > mx) et = 1'b1;
`endif
    elen = et ? mx : n;
    ep   = (elen < eff);
    if (ep) elen = eff;
  endfunction

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || st_q.size() != 0) && t < 5000) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_beats_left", 64'(exp_q.size()), 64'd0);
    chk("drain_status_left", 64'(st_q.size()), 64'd0);
  endtask

  initial begin
    logic ep, et;
    int   n, mn, mx, elen;
    rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    s_axis_tid = '0; s_axis_tdest = '0; s_axis_tuser = '0;
    length_min = '0; length_max = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_status", {status_valid, status_frame_pad, status_frame_truncate,
                       status_frame_length, status_frame_original_length}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors: n, base, min, max, pad, trunc, len, orig
    send_frame(2, 8'hA1, 4, 16, 1'b1, 1'b0, 4, 2);
`ifdef AXIS_FLA_TRUNCATE_EN
    send_frame(9, 8'h10, 4, 6, 1'b0, 1'b1, 6, 9);
`else
    send_frame(9, 8'h10, 4, 6, 1'b0, 1'b0, 9, 9);
`endif
    send_frame(6, 8'h30, 4, 6, 1'b0, 1'b0, 6, 6);
    send_frame(1, 8'h41, 0, 0, 1'b0, 1'b0, 1, 1);
    send_frame(3, 8'h50, 1, 0, 1'b0, 1'b0, 3, 3);
    send_frame(5, 8'h60, 5, 0, 1'b0, 1'b0, 5, 5);
    send_frame(4, 8'h67, 5, 0, 1'b1, 1'b0, 5, 4);
`ifdef AXIS_FLA_TRUNCATE_EN
    send_frame(1, 8'h80, 8, 3, 1'b1, 1'b0, 3, 1);
    send_frame(5, 8'h90, 2, 3, 1'b0, 1'b1, 3, 5);
    send_frame(4, 8'hB0, 2, 1, 1'b0, 1'b1, 1, 4);
`else
    send_frame(1, 8'h80, 8, 3, 1'b1, 1'b0, 8, 1);
    send_frame(5, 8'h90, 2, 3, 1'b0, 1'b0, 5, 5);
    send_frame(4, 8'hB0, 2, 1, 1'b0, 1'b0, 4, 4);
`endif
    send_frame(3, 8'hC0, 2, 3, 1'b0, 1'b0, 3, 3);
    drain();

    rnd_rdy = 1'b1;
    gaps    = 1'b1;
    for (int f = 0; f < 100; f++) begin
      n  = $urandom_range(1, 12);
      mn = $urandom_range(0, 8);
      mx = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 10);
      model(n, mn, mx, ep, et, elen);
      send_frame(n, 8'($urandom), mn, mx, ep, et, elen, n);
    end
    drain();

    // Reset while padding: frame is abandoned, no status, next frame is clean
    rnd_rdy = 1'b0;
    gaps    = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b0;
    length_min = 16'd8; length_max = 16'd0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h55; s_axis_tlast = 1'b1;
    wait_accept();
    s_axis_tvalid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("pad_s_tready", {s_axis_tready, m_axis_tvalid}, {1'b0, 1'b1});
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_s_tready", 64'(s_axis_tready), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    send_frame(3, 8'h70, 2, 16, 1'b0, 1'b0, 3, 3);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
